// File: rtl/width_downsizer.sv
// Serialises one DIN_W-bit valid/ready word into RATIO DOUT_W-bit beats,
// LSB- or MSB-first, with a zero-bubble handoff between consecutive words.
module width_downsizer #(
   parameter int DIN_W     = 32,
   parameter int DOUT_W    = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_up,
   output logic              ready_up,
   input  logic [DIN_W-1:0]  data_up,
   output logic              valid_down,
   input  logic              ready_down,
   output logic [DOUT_W-1:0] data_down,
   output logic              last_down,
   output logic              busy
);

   // state | meaning
   // IDLE  | no word held, ready for upstream
   // SEND  | word held, emitting beat beat_idx_q

   localparam int RATIO = DIN_W / DOUT_W;
   localparam int IDX_W = $clog2(RATIO);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   beat_idx_q, beat_idx_d;
   logic [DIN_W-1:0]   word_q, word_d;
   logic [IDX_W-1:0]   slice_sel;
   logic [DOUT_W-1:0]  slices [RATIO];
   logic               on_last;
   logic               up_fire;
   logic               down_fire;

   for (genvar i = 0; i < RATIO; i++) begin : g_slice
      assign slices[i] = word_q[i*DOUT_W +: DOUT_W];
   end

   assign slice_sel = LSB_FIRST ? beat_idx_q : (LAST_IDX - beat_idx_q);

   always_comb begin
      state_d    = state_q;
      beat_idx_d = beat_idx_q;
      word_d     = word_q;

      on_last    = (beat_idx_q == LAST_IDX);
      valid_down = (state_q == SEND);
      busy       = (state_q == SEND);
      last_down  = (state_q == SEND) && on_last;
      data_down  = (state_q == SEND) ? slices[slice_sel] : '0;
      // ready_down reaches ready_up only on the last beat, enabling back-to-back words
      ready_up   = (state_q == IDLE) || ((state_q == SEND) && on_last && ready_down);

      up_fire    = valid_up && ready_up;
      down_fire  = valid_down && ready_down;

      case (state_q)
         IDLE: begin
            if (up_fire) begin
               word_d     = data_up;
               beat_idx_d = '0;
               state_d    = SEND;
            end
         end
         SEND: begin
            if (down_fire) begin
               if (!on_last) begin
                  beat_idx_d = beat_idx_q + IDX_W'(1);
               end else if (up_fire) begin
                  word_d     = data_up;
                  beat_idx_d = '0;
               end else begin
                  beat_idx_d = '0;
                  state_d    = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         beat_idx_q <= '0;
         word_q     <= '0;
      end else begin
         state_q    <= state_d;
         beat_idx_q <= beat_idx_d;
         word_q     <= word_d;
      end
   end

endmodule
